// File: rtl/bram_rd_streamer_if.sv
// Ready/valid word stream leaving the BRAM read streamer.
interface bram_rd_streamer_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/bram_rd_streamer.sv
// Streams a burst of consecutive BRAM words onto a ready/valid interface.
// Optional stall counter output enabled by defining BRAM_RD_STREAMER_STATS_EN.
module bram_rd_streamer #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clkb,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_enb,
  output logic                  ram_regceb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  bram_rd_streamer_if.master    m_axis
`ifdef BRAM_RD_STREAMER_STATS_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned Depth = READ_LATENCY + 2;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned OccW  = CntW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_ram_addrb;
  logic [ADDR_WIDTH:0]   r_issue_left;
  logic [ADDR_WIDTH:0]   r_xfer_left;
  logic                  r_enb;
  logic                  r_done;
  logic [READ_LATENCY-1:0] r_vld;

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [CntW-1:0]       r_cnt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [OccW-1:0]       w_occ;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_push = r_vld[READ_LATENCY-1];
  assign w_pop  = m_axis.m_valid && m_axis.m_ready;

  // Every issued read already owns a FIFO slot, so a returning word always fits.
  always_comb begin
    w_occ = OccW'(r_cnt) + OccW'(r_enb);
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_occ = w_occ + OccW'(r_vld[i]);
    end
    w_occ = w_occ - OccW'(w_pop);
  end

  assign w_issue = (r_state == StRun) && (r_issue_left != '0) && (w_occ < OccW'(Depth));

  always_ff @(posedge clkb) begin
    if (rstb) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_ram_addrb  <= '0;
      r_issue_left <= '0;
      r_xfer_left  <= '0;
      r_enb        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_enb  <= w_issue;
      if (w_issue) begin
        r_ram_addrb  <= r_addr;
        r_addr       <= r_addr + ADDR_WIDTH'(1);
        r_issue_left <= r_issue_left - (ADDR_WIDTH + 1)'(1);
      end
      if (w_pop && (r_xfer_left != '0)) begin
        r_xfer_left <= r_xfer_left - (ADDR_WIDTH + 1)'(1);
      end
      case (r_state)
        StIdle: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= StRun;
              r_addr       <= base_addr;
              r_issue_left <= len;
              r_xfer_left  <= len;
            end
          end
        end
        StRun: begin
          if (w_issue && (r_issue_left == (ADDR_WIDTH + 1)'(1))) r_state <= StDrain;
        end
        StDrain: begin
          if (w_pop && (r_xfer_left == (ADDR_WIDTH + 1)'(1))) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clkb) begin
    if (rstb) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= r_enb;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clkb) begin
    if (rstb) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= ram_doutb;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != StIdle);
  assign done           = r_done;
  assign ram_addrb      = r_ram_addrb;
  assign ram_enb        = r_enb;
  assign ram_regceb     = (READ_LATENCY == 2) ? r_vld[0] : 1'b0;
  assign m_axis.m_valid = (r_cnt != '0);
  assign m_axis.m_data  = r_mem[r_rptr];

`ifdef BRAM_RD_STREAMER_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clkb) begin
    if (rstb) begin
      r_stall_cnt <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_stall_cnt <= '0;
    end else if (m_axis.m_valid && !m_axis.m_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Scoreboard bench for bram_rd_streamer with a behavioural two-stage BRAM read port.
module tb_bram_rd_streamer;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 9;
  localparam int unsigned RL = 2;

  logic          clkb = 1'b0;
  logic          rstb = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addrb;
  logic          ram_enb;
  logic          ram_regceb;
  logic [DW-1:0] ram_doutb;
  logic [DW-1:0] r_lat;
`ifdef BRAM_RD_STREAMER_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  bram_rd_streamer_if #(.DATA_WIDTH(DW)) m_axis ();

  bram_rd_streamer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(RL)
  ) u_dut (
    .clkb      (clkb),
    .rstb      (rstb),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_addrb (ram_addrb),
    .ram_enb   (ram_enb),
    .ram_regceb(ram_regceb),
    .ram_doutb (ram_doutb),
    .m_axis    (m_axis)
`ifdef BRAM_RD_STREAMER_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clkb = ~clkb;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {16'hC0DE, 7'd0, a, 16'h5A5A, 7'd0, ~a};
  endfunction

  always @(posedge clkb) begin
    if (RL == 1) begin
      if (ram_enb) ram_doutb <= ram_word(ram_addrb);
    end else begin
      if (ram_enb) r_lat <= ram_word(ram_addrb);
      if (ram_regceb) ram_doutb <= r_lat;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  int cyc = 0, n_issued = 0, n_xfer = 0, done_cnt = 0, done_cyc = -1;
  int first_enb = -1, last_enb = -1, first_vld = -1, last_xfer = -1;
  int max_occ = 0, stall_model = 0;
  int ready_mode = 0, low_left = 0;

  // Monitor: samples mid-cycle, pops scoreboard entries as reads and transfers happen.
  initial forever begin
    @(negedge clkb);
    cyc++;
    if (ram_enb) begin
      n_issued++;
      if (first_enb < 0) first_enb = cyc;
      last_enb = cyc;
      if (addr_q.size() == 0) check_eq("extra_read_enb", 64'(ram_enb), 64'd0);
      else check_eq("rd_addr", 64'(ram_addrb), 64'(addr_q.pop_front()));
    end
    if (m_axis.m_valid && first_vld < 0) first_vld = cyc;
    if (m_axis.m_valid && !m_axis.m_ready) stall_model++;
    if (m_axis.m_valid && m_axis.m_ready) begin
      n_xfer++;
      last_xfer = cyc;
      if (data_q.size() == 0) check_eq("extra_m_valid", 64'(m_axis.m_valid), 64'd0);
      else check_eq("word", m_axis.m_data, data_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (n_issued - n_xfer > max_occ) max_occ = n_issued - n_xfer;
  end

  task automatic step();
    @(posedge clkb);
    #1;
    case (ready_mode)
      0: m_axis.m_ready = 1'b1;
      1: begin
        if (low_left > 0) begin
          m_axis.m_ready = 1'b0;
          low_left--;
        end else if ($urandom_range(0, 7) == 0) begin
          m_axis.m_ready = 1'b0;
          low_left = 9;
        end else begin
          m_axis.m_ready = 1'($urandom_range(0, 1));
        end
      end
      default: m_axis.m_ready = 1'b0;
    endcase
  endtask

  task automatic clear_track();
    first_enb = -1; last_enb = -1; first_vld = -1; last_xfer = -1;
    n_issued = 0; n_xfer = 0; done_cnt = 0; done_cyc = -1;
    max_occ = 0; stall_model = 0;
  endtask

  task automatic push_expect(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(AW'(int'(b) + i));
      data_q.push_back(ram_word(AW'(int'(b) + i)));
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input int n, input int mode,
                           input bit restart, input string tag);
    clear_track();
    push_expect(b, n);
    ready_mode = mode;
    base_addr  = b;
    len        = (AW + 1)'(n);
    start      = 1'b1;
    step();
    start = 1'b0;
    @(negedge clkb);
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    if (restart) begin
      repeat (3) step();
      base_addr = 9'h100;
      len       = 10'd5;
      start     = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    check_eq({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (4) step();
    check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_done_timing"}, 64'(done_cyc), 64'(last_xfer + 1));
    check_eq({tag, "_n_issued"}, 64'(n_issued), 64'(n));
    check_eq({tag, "_n_xfer"}, 64'(n_xfer), 64'(n));
    check_eq({tag, "_addr_left"}, 64'(addr_q.size()), 64'd0);
    check_eq({tag, "_data_left"}, 64'(data_q.size()), 64'd0);
    check_eq({tag, "_occ_le_depth"}, 64'(max_occ <= int'(RL + 2)), 64'd1);
    check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
    addr_q.delete();
    data_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int xfer_at_rst;
    m_axis.m_ready = 1'b1;
    repeat (3) step();
    @(negedge clkb);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_enb", 64'(ram_enb), 64'd0);
    check_eq("rst_regceb", 64'(ram_regceb), 64'd0);
    check_eq("rst_addrb", 64'(ram_addrb), 64'd0);
    check_eq("rst_valid", 64'(m_axis.m_valid), 64'd0);
    check_eq("rst_data", m_axis.m_data, 64'd0);
    rstb = 1'b0;
    step();

    run_burst(9'h010, 8, 0, 1'b0, "basic");
    check_eq("basic_first_valid_lat", 64'(first_vld - first_enb), 64'(RL + 1));
    check_eq("basic_enb_contiguous", 64'(last_enb - first_enb), 64'd7);

    run_burst(9'h1FE, 4, 0, 1'b0, "wrap");

    run_burst(9'h080, 16, 1, 1'b0, "rand");
`ifdef BRAM_RD_STREAMER_STATS_EN
    check_eq("rand_stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif

    // Zero-length request.
    clear_track();
    ready_mode = 0;
    base_addr  = 9'h033;
    len        = '0;
    start      = 1'b1;
    step();
    start = 1'b0;
    @(negedge clkb);
    check_eq("len0_done", 64'(done), 64'd1);
    repeat (6) step();
    check_eq("len0_no_reads", 64'(n_issued), 64'd0);
    check_eq("len0_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("len0_busy", 64'(busy), 64'd0);

    run_burst(9'h040, 8, 0, 1'b1, "restart");

    // Reset in the middle of a burst, right after the third transfer.
    clear_track();
    push_expect(9'h0C0, 8);
    ready_mode = 0;
    base_addr  = 9'h0C0;
    len        = 10'd8;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && n_xfer < 3; i++) step();
    check_eq("mrst_xfer_before", 64'(n_xfer), 64'd3);
    ready_mode     = 2;
    m_axis.m_ready = 1'b0;
    rstb           = 1'b1;
    step();
    @(negedge clkb);
    check_eq("mrst_busy", 64'(busy), 64'd0);
    check_eq("mrst_done", 64'(done), 64'd0);
    check_eq("mrst_enb", 64'(ram_enb), 64'd0);
    check_eq("mrst_regceb", 64'(ram_regceb), 64'd0);
    check_eq("mrst_addrb", 64'(ram_addrb), 64'd0);
    check_eq("mrst_valid", 64'(m_axis.m_valid), 64'd0);
    check_eq("mrst_data", m_axis.m_data, 64'd0);
`ifdef BRAM_RD_STREAMER_STATS_EN
    check_eq("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    rstb = 1'b0;
    addr_q.delete();
    data_q.delete();
    xfer_at_rst = n_xfer;
    done_cnt    = 0;
    ready_mode  = 0;
    repeat (10) step();
    check_eq("mrst_no_words", 64'(n_xfer), 64'(xfer_at_rst));
    check_eq("mrst_no_done", 64'(done_cnt), 64'd0);

    run_burst(9'h1F0, 2, 0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_rd_streamer.md
BRAM_RD_STREAMER -- requirements
Module: bram_rd_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning RAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning RAM read address width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, meaning RAM enb-to-doutb latency; legal values are 1 (no output register) and 2 (output register).
REQ-004 SHALL have port clkb, input, 1, clock; all logic on its rising edge.
REQ-005 SHALL have port rstb, input, 1, reset (synchronous, active-high).
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a burst.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH, first word address, sampled with start.
REQ-008 SHALL have port len, input, ADDR_WIDTH+1, word count, sampled with start.
REQ-009 SHALL have port busy, output, 1, high from the cycle after accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at burst completion.
REQ-011 SHALL have port ram_addrb, output, ADDR_WIDTH, RAM read address.
REQ-012 SHALL have port ram_enb, output, 1, RAM read enable; one pulse per issued read.
REQ-013 SHALL have port ram_regceb, output, 1, RAM output register enable.
REQ-014 SHALL have port ram_doutb, input, DATA_WIDTH, RAM read data.
REQ-015 SHALL have port m_data, output, DATA_WIDTH, streamed word.
REQ-016 SHALL have port m_valid, output, 1, m_data valid.
REQ-017 SHALL have port m_ready, input, 1, downstream accept; transfer when m_valid and m_ready.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN; start in IDLE with len>0 goes to RUN; start while not IDLE is ignored.
REQ-019 SHALL, for start with len=0, pulse done the next cycle, issue no reads, stay in IDLE.
REQ-020 SHALL in RUN issue reads at base_addr, base_addr+1, ... incrementing modulo 2^ADDR_WIDTH (wraps past all-ones to 0).
REQ-021 SHALL track in-flight reads with a READ_LATENCY-deep valid shift register; ram_doutb is captured into the output FIFO when the last stage is valid.
REQ-022 SHALL drive ram_regceb equal to valid-stage-1 when READ_LATENCY=2, and 0 when READ_LATENCY=1.
REQ-023 SHALL contain a FIFO of depth READ_LATENCY+2 and SHALL issue a read only when (FIFO count + in-flight count) < depth, so no returned word is ever dropped.
REQ-024 SHALL sustain one word per cycle when m_ready is held high; first m_valid occurs READ_LATENCY+1 cycles after the first ram_enb.
REQ-025 SHALL move RUN to DRAIN in the cycle the len-th read issues; DRAIN to IDLE when the len-th word transfers; done pulses in that same cycle.
REQ-026 SHALL hold m_data stable while m_valid is high and m_ready low.
REQ-027 SHALL handle a FIFO push and pop in the same cycle at full or empty without loss or duplication.

Reset
REQ-028 SHALL on rstb force IDLE, clear FIFO, in-flight pipeline and counters; busy, done, ram_enb, ram_regceb, m_valid = 0; ram_addrb, m_data = 0.
REQ-029 SHALL on rstb mid-burst discard in-flight data; no m_valid or done follows until a new start.

Configuration
REQ-030 SHALL, when BRAM_RD_STREAMER_STATS_EN is defined, add output stall_cnt (32 bits, reset 0, increments each cycle m_valid=1 and m_ready=0, saturates at all-ones, clears on accepted start).
REQ-031 SHALL, without BRAM_RD_STREAMER_STATS_EN, omit stall_cnt entirely; all other behaviour is identical.

Verification
REQ-032 SHALL test: base_addr=0x010, len=8, m_ready=1, READ_LATENCY=2 -> addresses 0x010..0x017 on consecutive cycles, 8 words in order, first m_valid 3 cycles after first ram_enb, one done pulse.
REQ-033 SHALL test: base_addr=0x1FE, len=4 -> addresses 0x1FE, 0x1FF, 0x000, 0x001.
REQ-034 SHALL test: len=16, m_ready toggled randomly with 10-cycle low stretches -> no lost or duplicate words; in-flight plus FIFO never exceeds 4; stall_cnt equals total m_valid&!m_ready cycles (with BRAM_RD_STREAMER_STATS_EN).
REQ-035 SHALL test: start with len=0 -> done next cycle, ram_enb never asserted.
REQ-036 SHALL test: rstb asserted after 3 of 8 words transferred -> all outputs 0 next cycle; a new start with len=2 then streams exactly 2 correct words.
REQ-037 SHALL test: start pulsed again during RUN -> ignored; original burst completes unchanged.
